lock_code_sender: RTL



---
 rtl/lock_pkg.sv | 23 ++
 rtl/lock_code_sender_if.sv | 30 +++
 rtl/lock_cycle_timer.sv | 30 +++
 rtl/lock_code_sender.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the code-lock sender and the lock's own bench.
//   state_t      : sender FSM encoding, also exported on the debug port s
//   DEFAULT_CODE : reference unlock code
//   cnt_w()      : width of a counter that must hold 0..n-1, at least 1 bit
package lock_pkg;

  localparam int unsigned DEF_CODE_LEN = 5;
  localparam logic [DEF_CODE_LEN-1:0] DEFAULT_CODE = 5'b01011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_PRESS = 3'd2,
    S_GAP   = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lock_code_sender_if.sv
// Bus between a requester, the sender and the lock.
//   slave  : the sender's view (request/feedback in, buttons/status out)
//   master : the requester/lock side view
interface lock_code_sender_if
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN = DEF_CODE_LEN
);
  logic                start;
  logic [CODE_LEN-1:0] code;
  logic                unlc;
  logic                b0;
  logic                b1;
  logic                lock_rst_n;
  logic                busy;
  logic                done;
  logic                pass;
  logic                fail;
  logic [2:0]          s;

  modport slave (
    input  start, code, unlc,
    output b0, b1, lock_rst_n, busy, done, pass, fail, s
  );

  modport master (
    output start, code, unlc,
    input  b0, b1, lock_rst_n, busy, done, pass, fail, s
  );
endinterface

// File: rtl/lock_cycle_timer.sv
// Loadable down-counter with terminal-count flag.
//   load     : load load_val (takes priority over dec)
//   dec      : decrement by one, holds at zero
//   tc_c     : count is zero (decoded from the count register)
module lock_cycle_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc_c
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc_c = (cnt == '0);

endmodule

// File: rtl/lock_code_sender.sv
// Enters a latched code into a two-button lock, MSB first, one press per bit,
// then waits a bounded time for unlc and reports pass/fail.
//   clk, rst : clock, async active-high reset
//   bus      : start/code/unlc in; b0/b1/lock_rst_n/busy/done/pass/fail/s out
module lock_code_sender
  import lock_pkg::*;
#(
  parameter int unsigned CODE_LEN = 5,
  parameter int unsigned GAP      = 2,
  parameter int unsigned TIMEOUT  = 4
) (
  input  logic                clk,
  input  logic                rst,
  lock_code_sender_if.slave   bus
);

  localparam int unsigned IDX_W = cnt_w(CODE_LEN);
  localparam int unsigned GAP_W = cnt_w(GAP);
  localparam int unsigned TO_W  = cnt_w(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CODE_LEN-1:0] code_q, code_n;
  logic                pass_q, pass_n;
  logic                fail_q, fail_n;
  logic                b0_q, b1_q, lock_rst_n_q, busy_q, done_q;
  logic                gap_load, gap_dec, gap_tc;
  logic                to_load, to_dec, to_tc;

  lock_cycle_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_W'(GAP - 1)),
    .dec      (gap_dec),
    .tc_c     (gap_tc)
  );

  lock_cycle_timer #(.WIDTH(TO_W)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TO_W'(TIMEOUT - 1)),
    .dec      (to_dec),
    .tc_c     (to_tc)
  );

  // Next-state logic. code_q is shifted after each press so its MSB is
  // always the bit of the next press.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    code_n   = code_q;
    pass_n   = pass_q;
    fail_n   = fail_q;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    to_load  = 1'b0;
    to_dec   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          code_n  = bus.code;
          idx_n   = '0;
          pass_n  = 1'b0;
          fail_n  = 1'b0;
          state_n = S_CLEAR;
        end
      end
      S_CLEAR: state_n = S_PRESS;
      S_PRESS: begin
        code_n = code_q << 1;
        if (idx == IDX_LAST) begin
          to_load = 1'b1;
          state_n = S_WAIT;
        end else begin
          gap_load = 1'b1;
          state_n  = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_tc) begin
          idx_n   = idx + 1'b1;
          state_n = S_PRESS;
        end else begin
          gap_dec = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.unlc) begin
          pass_n  = 1'b1;
          state_n = S_DONE;
        end else if (to_tc) begin
          fail_n  = 1'b1;
          state_n = S_DONE;
        end else begin
          to_dec = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; outputs are computed from the next state
  // so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      idx          <= '0;
      code_q       <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      b0_q         <= 1'b0;
      b1_q         <= 1'b0;
      lock_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      code_q       <= code_n;
      pass_q       <= pass_n;
      fail_q       <= fail_n;
      b0_q         <= (state_n == S_PRESS) && !code_n[CODE_LEN-1];
      b1_q         <= (state_n == S_PRESS) &&  code_n[CODE_LEN-1];
      lock_rst_n_q <= (state_n != S_CLEAR);
      busy_q       <= (state_n != S_IDLE);
      done_q       <= (state_n == S_DONE);
    end
  end

  assign bus.b0         = b0_q;
  assign bus.b1         = b1_q;
  assign bus.lock_rst_n = lock_rst_n_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.fail       = fail_q;
  assign bus.s          = state;

endmodule
